puck_engine: RTL and testbench



---
 rtl/puck_engine_pkg.sv | 24 ++
 rtl/puck_engine_bcd_score_counter.sv | 38 +++
 rtl/puck_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_puck_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puck_engine_pkg.sv
// Shared definitions for the puck engine: game state encoding, BCD digit
// widths and a helper that turns a two-digit BCD score into binary.
package puck_engine_pkg;

   localparam int ONES_W = 4;
   localparam int TENS_W = 3;

   localparam logic [ONES_W-1:0] ONES_MAX = 4'd9;
   localparam logic [TENS_W-1:0] TENS_MAX = 3'd7;

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_GOAL  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   // Binary value of a tens/ones pair (0..79).
   function automatic logic [6:0] bcd_value(input logic [TENS_W-1:0] tens,
                                            input logic [ONES_W-1:0] ones);
      return 7'(tens) * 7'd10 + 7'(ones);
   endfunction

endpackage

// File: rtl/puck_engine_bcd_score_counter.sv
// Two-digit BCD score counter. inc adds one goal, clr zeroes both digits,
// and the count saturates at 79.
module bcd_score_counter
   import puck_engine_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              clr,
   output logic [ONES_W-1:0] ones,
   output logic [TENS_W-1:0] tens
);

   logic [ONES_W-1:0] ones_reg;
   logic [TENS_W-1:0] tens_reg;

   // Digit registers: clear wins over increment; 79 holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones_reg <= '0;
         tens_reg <= '0;
      end else if (clr) begin
         ones_reg <= '0;
         tens_reg <= '0;
      end else if (inc) begin
         if (ones_reg != ONES_MAX) begin
            ones_reg <= ones_reg + 1'b1;
         end else if (tens_reg != TENS_MAX) begin
            ones_reg <= '0;
            tens_reg <= tens_reg + 1'b1;
         end
      end
   end

   assign ones = ones_reg;
   assign tens = tens_reg;

endmodule

// File: rtl/puck_engine.sv
// Air-hockey game core: puck motion, wall/paddle rebounds, goals, BCD
// scoring and serve/goal/game-over sequencing, stepped once per frame_tick.
// Optional feature macro: PUCK_ENGINE_SPEEDUP_EN (paddle hits raise speed
// by one, capped at MAX_SPEED).
module puck_engine
   import puck_engine_pkg::*;
#(
   parameter int FIELD_W      = 640,
   parameter int FIELD_H      = 480,
   parameter int POS_W        = 10,
   parameter int PUCK_SZ      = 8,
   parameter int GOAL_TOP     = 160,
   parameter int GOAL_BOT     = 320,
   parameter int PAD_W        = 8,
   parameter int PAD_H        = 64,
   parameter int PAD_X1       = 16,
   parameter int PAD_X2       = 616,
   parameter int SPEED        = 2,
   parameter int MAX_SPEED    = 6,
   parameter int WIN_SCORE    = 7,
   parameter int PAUSE_FRAMES = 60
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic              btns_v,
   input  logic [POS_W-1:0]  p1_y,
   input  logic [POS_W-1:0]  p2_y,
   output logic [POS_W-1:0]  puck_x,
   output logic [POS_W-1:0]  puck_y,
   output logic [ONES_W-1:0] p1_ones,
   output logic [ONES_W-1:0] p2_ones,
   output logic [TENS_W-1:0] p1_tens,
   output logic [TENS_W-1:0] p2_tens,
   output logic [1:0]        state,
   output logic              goal_p1,
   output logic              goal_p2,
   output logic              game_over
);

   // Signed working width leaves headroom for overshoot past either wall.
   localparam int SW    = POS_W + 2;
   localparam int SPD_W = $clog2(((SPEED > MAX_SPEED) ? SPEED : MAX_SPEED) + 1);
   localparam int PC_W  = $clog2(PAUSE_FRAMES + 1);

   localparam logic [POS_W-1:0] CX         = POS_W'((FIELD_W - PUCK_SZ) / 2);
   localparam logic [POS_W-1:0] CY         = POS_W'((FIELD_H - PUCK_SZ) / 2);
   localparam logic [SPD_W-1:0] SPEED_INIT = SPD_W'(SPEED);
   localparam logic [PC_W-1:0]  PAUSE_LAST = PC_W'(PAUSE_FRAMES - 1);

   localparam logic signed [SW-1:0] S_PUCK = SW'(PUCK_SZ);
   localparam logic signed [SW-1:0] S_FW   = SW'(FIELD_W);
   localparam logic signed [SW-1:0] S_FH   = SW'(FIELD_H);
   localparam logic signed [SW-1:0] S_GT   = SW'(GOAL_TOP);
   localparam logic signed [SW-1:0] S_GB   = SW'(GOAL_BOT);
   localparam logic signed [SW-1:0] S_PW   = SW'(PAD_W);
   localparam logic signed [SW-1:0] S_PH   = SW'(PAD_H);
   localparam logic signed [SW-1:0] S_PX1  = SW'(PAD_X1);
   localparam logic signed [SW-1:0] S_PX2  = SW'(PAD_X2);
   localparam logic signed [SW-1:0] S_ZERO = '0;

   state_t            state_reg, state_next;
   logic [POS_W-1:0]  x_reg, x_next, y_reg, y_next;
   logic              dx_neg_reg, dx_neg_next, dy_neg_reg, dy_neg_next;
   logic [SPD_W-1:0]  speed_reg, speed_next;
   logic [PC_W-1:0]   pause_reg, pause_next;
   logic              btn_prev_reg;
   logic              goal_p1_reg, goal_p2_reg, game_over_reg;

   logic [1:0]        goal_inc;
   logic              clr_scores;
   logic [1:0]        will_win;
   logic [ONES_W-1:0] ones_arr [2];
   logic [TENS_W-1:0] tens_arr [2];

   // Puck rectangle at (px,py) strictly overlaps a paddle at (padx,pady).
   function automatic logic overlaps(input logic signed [SW-1:0] px,
                                     input logic signed [SW-1:0] py,
                                     input logic signed [SW-1:0] padx,
                                     input logic signed [SW-1:0] pady);
      return (px < padx + S_PW) && (px + S_PUCK > padx) &&
             (py < pady + S_PH) && (py + S_PUCK > pady);
   endfunction

   // Index 0 is player 1, index 1 is player 2.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_score
         bcd_score_counter u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (goal_inc[gi]),
            .clr  (clr_scores),
            .ones (ones_arr[gi]),
            .tens (tens_arr[gi])
         );
         assign will_win[gi] =
            (bcd_value(tens_arr[gi], ones_arr[gi]) + 7'd1) == 7'(WIN_SCORE);
      end
   endgenerate

   logic                   btn_edge, hit_p1, hit_p2, in_mouth;
   logic                   at_left, at_right, at_top, at_bot, dx_adj;
   logic signed [SW-1:0]   step, nx, ny, nx_adj, nx_fin, ny_fin;

   // Next-state and frame-step logic: paddle, then end walls, then side walls.
   always_comb begin
      state_next  = state_reg;
      x_next      = x_reg;
      y_next      = y_reg;
      dx_neg_next = dx_neg_reg;
      dy_neg_next = dy_neg_reg;
      speed_next  = speed_reg;
      pause_next  = pause_reg;
      goal_inc    = 2'b00;
      clr_scores  = 1'b0;

      btn_edge = btns_v & ~btn_prev_reg;
      step     = SW'(speed_reg);
      nx       = $signed({2'b00, x_reg}) + (dx_neg_reg ? -step : step);
      ny       = $signed({2'b00, y_reg}) + (dy_neg_reg ? -step : step);
      hit_p1   = dx_neg_reg  && overlaps(nx, ny, S_PX1, $signed({2'b00, p1_y}));
      hit_p2   = !dx_neg_reg && overlaps(nx, ny, S_PX2, $signed({2'b00, p2_y}));

      nx_adj = nx;
      dx_adj = dx_neg_reg;
      if (hit_p1) begin
         nx_adj = S_PX1 + S_PW;
         dx_adj = 1'b0;
      end else if (hit_p2) begin
         nx_adj = S_PX2 - S_PUCK;
         dx_adj = 1'b1;
      end

      in_mouth = (ny >= S_GT) && (ny + S_PUCK <= S_GB);
      at_left  = nx_adj <= S_ZERO;
      at_right = nx_adj + S_PUCK >= S_FW;
      at_top   = ny <= S_ZERO;
      at_bot   = ny + S_PUCK >= S_FH;
      nx_fin   = at_left ? S_ZERO : (at_right ? S_FW - S_PUCK : nx_adj);
      ny_fin   = at_top  ? S_ZERO : (at_bot   ? S_FH - S_PUCK : ny);

      case (state_reg)
         ST_SERVE: begin
            if (btn_edge) state_next = ST_PLAY;
         end
         ST_PLAY: begin
            if (frame_tick) begin
               if ((at_left || at_right) && in_mouth) begin
                  // Left end goal scores for P2, right end for P1; the
                  // serve then heads toward whoever conceded.
                  goal_inc    = at_left ? 2'b10 : 2'b01;
                  dx_neg_next = at_left;
                  x_next      = CX;
                  y_next      = CY;
                  speed_next  = SPEED_INIT;
                  pause_next  = '0;
                  state_next  = (at_left ? will_win[1] : will_win[0]) ? ST_OVER : ST_GOAL;
               end else begin
                  x_next      = POS_W'(nx_fin);
                  y_next      = POS_W'(ny_fin);
                  dx_neg_next = (at_left || at_right) ? ~dx_adj : dx_adj;
                  dy_neg_next = (at_top || at_bot) ? ~dy_neg_reg : dy_neg_reg;
`ifdef PUCK_ENGINE_SPEEDUP_EN
                  if (hit_p1 || hit_p2) begin
                     speed_next = (speed_reg >= SPD_W'(MAX_SPEED)) ?
                                  SPD_W'(MAX_SPEED) : speed_reg + 1'b1;
                  end
`endif
               end
            end
         end
         ST_GOAL: begin
            if (frame_tick) begin
               if (pause_reg == PAUSE_LAST) begin
                  pause_next = '0;
                  state_next = ST_SERVE;
               end else begin
                  pause_next = pause_reg + 1'b1;
               end
            end
         end
         ST_OVER: begin
            if (btn_edge) begin
               clr_scores = 1'b1;
               state_next = ST_SERVE;
            end
         end
         default: state_next = ST_SERVE;
      endcase
   end

   // State and output registers; reset places the puck at centre heading +x,+y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_SERVE;
         x_reg         <= CX;
         y_reg         <= CY;
         dx_neg_reg    <= 1'b0;
         dy_neg_reg    <= 1'b0;
         speed_reg     <= SPEED_INIT;
         pause_reg     <= '0;
         btn_prev_reg  <= 1'b0;
         goal_p1_reg   <= 1'b0;
         goal_p2_reg   <= 1'b0;
         game_over_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         dx_neg_reg    <= dx_neg_next;
         dy_neg_reg    <= dy_neg_next;
         speed_reg     <= speed_next;
         pause_reg     <= pause_next;
         btn_prev_reg  <= btns_v;
         goal_p1_reg   <= goal_inc[0];
         goal_p2_reg   <= goal_inc[1];
         game_over_reg <= (state_next == ST_OVER);
      end
   end

   assign puck_x    = x_reg;
   assign puck_y    = y_reg;
   assign p1_ones   = ones_arr[0];
   assign p1_tens   = tens_arr[0];
   assign p2_ones   = ones_arr[1];
   assign p2_tens   = tens_arr[1];
   assign state     = state_reg;
   assign goal_p1   = goal_p1_reg;
   assign goal_p2   = goal_p2_reg;
   assign game_over = game_over_reg;

endmodule

// File: tb/tb_puck_engine.sv
// Randomized bench for puck_engine with a scoreboard: the driver steps an
// integer game model and queues the expected outputs; a monitor pops one
// entry after every clock edge and compares.
module tb_puck_engine;

   localparam int FIELD_W = 160, FIELD_H = 120, POS_W = 10, PUCK_SZ = 8;
   localparam int GOAL_TOP = 40, GOAL_BOT = 80, PAD_W = 8, PAD_H = 24;
   localparam int PAD_X1 = 8, PAD_X2 = 144, SPEED = 2, MAX_SPEED = 5;
   localparam int WIN_SCORE = 11, PAUSE_FRAMES = 5;
   localparam int S_SERVE = 0, S_PLAY = 1, S_GOAL = 2, S_OVER = 3;

   logic             clk = 1'b0;
   logic             rst, frame_tick, btns_v;
   logic [POS_W-1:0] p1_y, p2_y, puck_x, puck_y;
   logic [3:0]       p1_ones, p2_ones;
   logic [2:0]       p1_tens, p2_tens;
   logic [1:0]       state;
   logic             goal_p1, goal_p2, game_over;

   puck_engine #(
      .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .POS_W(POS_W), .PUCK_SZ(PUCK_SZ),
      .GOAL_TOP(GOAL_TOP), .GOAL_BOT(GOAL_BOT), .PAD_W(PAD_W), .PAD_H(PAD_H),
      .PAD_X1(PAD_X1), .PAD_X2(PAD_X2), .SPEED(SPEED), .MAX_SPEED(MAX_SPEED),
      .WIN_SCORE(WIN_SCORE), .PAUSE_FRAMES(PAUSE_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .btns_v(btns_v),
      .p1_y(p1_y), .p2_y(p2_y), .puck_x(puck_x), .puck_y(puck_y),
      .p1_ones(p1_ones), .p2_ones(p2_ones), .p1_tens(p1_tens), .p2_tens(p2_tens),
      .state(state), .goal_p1(goal_p1), .goal_p2(goal_p2), .game_over(game_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x, y, s1, s2, st, g1, g2;
      bit txn;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0, n_errors = 0, txn_id = 0, goals_seen = 0;

   // Behavioural game model: plain integers, scores kept in binary.
   int m_x, m_y, m_dx, m_dy, m_spd, m_s1, m_s2, m_st, m_pause, m_g1, m_g2;
   bit m_bprev;

   function automatic void model_reset();
      m_x = (FIELD_W - PUCK_SZ) / 2;  m_y = (FIELD_H - PUCK_SZ) / 2;
      m_dx = 1; m_dy = 1; m_spd = SPEED; m_s1 = 0; m_s2 = 0;
      m_st = S_SERVE; m_pause = 0; m_g1 = 0; m_g2 = 0; m_bprev = 1'b0;
   endfunction

   function automatic bit ovl(int px, int py, int padx, int pady);
      return px < padx + PAD_W && px + PUCK_SZ > padx &&
             py < pady + PAD_H && py + PUCK_SZ > pady;
   endfunction

   function automatic void score(int who);
      bit win;
      if (who == 1) begin
         m_s1 = (m_s1 >= 79) ? 79 : m_s1 + 1; win = (m_s1 == WIN_SCORE);
         m_g1 = 1; m_dx = 1;
      end else begin
         m_s2 = (m_s2 >= 79) ? 79 : m_s2 + 1; win = (m_s2 == WIN_SCORE);
         m_g2 = 1; m_dx = -1;
      end
      m_x = (FIELD_W - PUCK_SZ) / 2;  m_y = (FIELD_H - PUCK_SZ) / 2;
      m_spd = SPEED; m_pause = 0;
      m_st = win ? S_OVER : S_GOAL;
   endfunction

   function automatic void model_move(int y1, int y2);
      int nx = m_x + m_dx * m_spd;
      int ny = m_y + m_dy * m_spd;
      bit hit = 1'b0, mouth;
      if (m_dx < 0 && ovl(nx, ny, PAD_X1, y1)) begin
         m_dx = 1; nx = PAD_X1 + PAD_W; hit = 1'b1;
      end else if (m_dx > 0 && ovl(nx, ny, PAD_X2, y2)) begin
         m_dx = -1; nx = PAD_X2 - PUCK_SZ; hit = 1'b1;
      end
      mouth = ny >= GOAL_TOP && ny + PUCK_SZ <= GOAL_BOT;
      if (nx <= 0 && mouth) score(2);
      else if (nx + PUCK_SZ >= FIELD_W && mouth) score(1);
      else begin
         if (nx <= 0) begin nx = 0; m_dx = -m_dx; end
         else if (nx + PUCK_SZ >= FIELD_W) begin nx = FIELD_W - PUCK_SZ; m_dx = -m_dx; end
         if (ny <= 0) begin ny = 0; m_dy = -m_dy; end
         else if (ny + PUCK_SZ >= FIELD_H) begin ny = FIELD_H - PUCK_SZ; m_dy = -m_dy; end
`ifdef PUCK_ENGINE_SPEEDUP_EN
         if (hit) m_spd = (m_spd + 1 > MAX_SPEED) ? MAX_SPEED : m_spd + 1;
`endif
         m_x = nx; m_y = ny;
      end
   endfunction

   function automatic bit model_step(bit tick, bit b, int y1, int y2);
      bit edge_seen = b && !m_bprev;
      m_bprev = b; m_g1 = 0; m_g2 = 0;
      case (m_st)
         S_SERVE: if (edge_seen) m_st = S_PLAY;
         S_PLAY:  if (tick) model_move(y1, y2);
         S_GOAL:  if (tick) begin
                     m_pause++;
                     if (m_pause >= PAUSE_FRAMES) begin m_pause = 0; m_st = S_SERVE; end
                  end
         default: if (edge_seen) begin m_s1 = 0; m_s2 = 0; m_st = S_SERVE; end
      endcase
      return edge_seen;
   endfunction

   function automatic exp_t snap(bit txn);
      exp_t e;
      e.x = m_x; e.y = m_y; e.s1 = m_s1; e.s2 = m_s2; e.st = m_st;
      e.g1 = m_g1; e.g2 = m_g2; e.txn = txn;
      return e;
   endfunction

   task automatic check(input exp_t e, input string tag);
      bit bad;
      n_checks++;
      bad = $isunknown({puck_x, puck_y, p1_ones, p1_tens, p2_ones, p2_tens,
                        state, goal_p1, goal_p2, game_over}) ||
            int'(puck_x) != e.x || int'(puck_y) != e.y ||
            int'(p1_tens) != e.s1 / 10 || int'(p1_ones) != e.s1 % 10 ||
            int'(p2_tens) != e.s2 / 10 || int'(p2_ones) != e.s2 % 10 ||
            int'(state) != e.st || int'(goal_p1) != e.g1 || int'(goal_p2) != e.g2 ||
            game_over != (e.st == S_OVER);
      if (bad) begin
         n_errors++;
         $display("FAIL %s #%0d: got st=%0d x=%0d y=%0d p1=%0d%0d p2=%0d%0d g=%0b%0b over=%0b, expected st=%0d x=%0d y=%0d p1=%0d p2=%0d g=%0d%0d over=%0b",
                  tag, n_checks, state, puck_x, puck_y, p1_tens, p1_ones, p2_tens, p2_ones,
                  goal_p1, goal_p2, game_over, e.st, e.x, e.y, e.s1, e.s2, e.g1, e.g2,
                  e.st == S_OVER);
      end else if (e.txn) begin
         txn_id++;
         $display("txn %0d %s: st=%0d pos=(%0d,%0d) score %0d-%0d goal=%0d%0d ok",
                  txn_id, tag, e.st, e.x, e.y, e.s1, e.s2, e.g1, e.g2);
      end
   endtask

   // Monitor: one expected entry per clock edge, compared just after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e, "step");
         end
      end
   end

   task automatic drive_cycle(input bit r, input bit tick, input bit b, input int y1, input int y2);
      bit ev;
      @(negedge clk);
      rst = r; frame_tick = tick; btns_v = b;
      p1_y = POS_W'(y1); p2_y = POS_W'(y2);
      if (r) begin
         model_reset();
         ev = 1'b1;
      end else begin
         ev = model_step(tick, b, y1, y2) | tick;
      end
      if (m_g1 || m_g2) goals_seen++;
      exp_q.push_back(snap(ev));
   endtask

   int btn_lvl = 0, pad1 = 0, pad2 = 0;

   function automatic int pick_pad();
      int v;
      case ($urandom_range(0, 3))
         0: begin
            v = m_y - 8;
            if (v < 0) v = 0;
            if (v > FIELD_H - PAD_H) v = FIELD_H - PAD_H;
         end
         1: v = $urandom_range(0, FIELD_H - PAD_H);
         default: v = (m_y < FIELD_H / 2) ? FIELD_H - PAD_H : 0;
      endcase
      return v;
   endfunction

   task automatic rand_cycles(input int n);
      bit tick;
      for (int i = 0; i < n; i++) begin
         tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) btn_lvl = 1 - btn_lvl;
         if (tick) begin pad1 = pick_pad(); pad2 = pick_pad(); end
         drive_cycle(1'b0, tick, btn_lvl[0], pad1, pad2);
      end
   endtask

   initial begin
      int budget;
      rst = 1'b1; frame_tick = 1'b0; btns_v = 1'b0; p1_y = '0; p2_y = '0;
      model_reset();
      repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);
      // Serve with a tick in the same cycle: only the transition happens.
      drive_cycle(1'b0, 1'b1, 1'b1, 0, 0);
      btn_lvl = 1;
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b1, 0, 0);
      rand_cycles(9000);

      // Get into PLAY, then hit rst between clock edges.
      budget = 4000;
      while (m_st != S_PLAY && budget > 0) begin
         rand_cycles(1);
         budget--;
      end
      if (m_st != S_PLAY) begin
         n_checks++; n_errors++;
         $display("FAIL reach_play: got model state %0d, required %0d", m_st, S_PLAY);
      end
      rand_cycles(7);
      @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check(snap(1'b1), "async_rst");
      drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);
      btn_lvl = 0;
      rand_cycles(9000);

      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++; n_errors++;
         $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
      end
      $display("info: goals observed %0d", goals_seen);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
